// File: rtl/hc595_receiver.sv
// Oversampling receiver for a 3-wire 74HC595 link (ds, sh_clk, st_clk) that presents each latched {seg, sel} frame.
// Optional HC595_RX_DIGIT_CAP_EN adds a per-digit segment capture bank (DATA_W must be 16).
module hc595_receiver #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_50mhz,
    input  logic              rst_n,
    input  logic              en,
    input  logic              ds,
    input  logic              sh_clk,
    input  logic              st_clk,
    output logic [DATA_W-1:0] data,
    output logic [7:0]        seg,
    output logic [7:0]        sel,
    output logic              valid,
    output logic              frame_err
`ifdef HC595_RX_DIGIT_CAP_EN
    ,
    output logic [63:0]       digits,
    output logic              sel_err
`endif
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

    logic [SYNC_STAGES-1:0] ds_sync_q;
    logic [SYNC_STAGES-1:0] sh_sync_q;
    logic [SYNC_STAGES-1:0] st_sync_q;
    logic                   sh_prev_q;
    logic                   st_prev_q;

    logic [DATA_W-1:0]      shreg_q, shreg_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_err_q, frame_err_d;

    logic                   ds_s_c;
    logic                   sh_rise_c;
    logic                   st_rise_c;
    logic                   frame_ok_c;

    // Equal-depth synchronisers keep ds aligned with the sh_clk edge it belongs to
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            ds_sync_q <= '0;
            sh_sync_q <= '0;
            st_sync_q <= '0;
            sh_prev_q <= 1'b0;
            st_prev_q <= 1'b0;
        end else begin
            ds_sync_q <= {ds_sync_q[SYNC_STAGES-2:0], ds};
            sh_sync_q <= {sh_sync_q[SYNC_STAGES-2:0], sh_clk};
            st_sync_q <= {st_sync_q[SYNC_STAGES-2:0], st_clk};
            sh_prev_q <= sh_sync_q[SYNC_STAGES-1];
            st_prev_q <= st_sync_q[SYNC_STAGES-1];
        end
    end

    // Edges seen while en is low are consumed, since prev tracks regardless of en
    assign ds_s_c     = ds_sync_q[SYNC_STAGES-1];
    assign sh_rise_c  = en & sh_sync_q[SYNC_STAGES-1] & ~sh_prev_q;
    assign st_rise_c  = en & st_sync_q[SYNC_STAGES-1] & ~st_prev_q;
    assign frame_ok_c = st_rise_c & (bit_cnt_q == CNT_FULL);

    // Latch sees pre-shift shreg/bit_cnt; a coincident shift starts the next frame
    always_comb begin
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        if (st_rise_c) begin
            if (frame_ok_c) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                frame_err_d = 1'b1;
            end
            bit_cnt_d = '0;
        end

        if (sh_rise_c) begin
            shreg_d = {shreg_q[DATA_W-2:0], ds_s_c};
            if (st_rise_c) begin
                bit_cnt_d = CNT_W'(1);
            end else if (bit_cnt_q != CNT_SAT) begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data      = data_q;
    assign seg       = data_q[DATA_W-1 -: 8];
    assign sel       = data_q[7:0];
    assign valid     = valid_q;
    assign frame_err = frame_err_q;

`ifdef HC595_RX_DIGIT_CAP_EN
    logic [63:0] digits_q, digits_d;
    logic        sel_err_q, sel_err_d;
    logic [3:0]  zero_cnt_c;
    logic [2:0]  zero_idx_c;

    // Active-low digit select: exactly one cleared bit names the digit being written
    always_comb begin
        zero_cnt_c = '0;
        zero_idx_c = '0;
        for (int i = 0; i < 8; i++) begin
            if (!shreg_q[i]) begin
                zero_cnt_c = zero_cnt_c + 4'd1;
                zero_idx_c = 3'(i);
            end
        end
    end

    always_comb begin
        digits_d  = digits_q;
        sel_err_d = 1'b0;
        if (frame_ok_c) begin
            if (zero_cnt_c == 4'd1) begin
                digits_d[{zero_idx_c, 3'b000} +: 8] = shreg_q[15:8];
            end else begin
                sel_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            digits_q  <= {8{8'hFF}};
            sel_err_q <= 1'b0;
        end else begin
            digits_q  <= digits_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign digits  = digits_q;
    assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_hc595_receiver.sv
// Directed bench for hc595_receiver: table of frames plus hand sequences for reset, en and digit capture.
module tb_hc595_receiver;

    logic        clk_50mhz = 1'b0;
    logic        rst_n;
    logic        en;
    logic        ds;
    logic        sh_clk;
    logic        st_clk;
    logic [15:0] data;
    logic [7:0]  seg;
    logic [7:0]  sel;
    logic        valid;
    logic        frame_err;
`ifdef HC595_RX_DIGIT_CAP_EN
    logic [63:0] digits;
    logic        sel_err;
    int          se_cnt;
    int          se_bad;
`endif

    always #10 clk_50mhz = ~clk_50mhz;

    hc595_receiver #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk_50mhz (clk_50mhz),
        .rst_n     (rst_n),
        .en        (en),
        .ds        (ds),
        .sh_clk    (sh_clk),
        .st_clk    (st_clk),
        .data      (data),
        .seg       (seg),
        .sel       (sel),
        .valid     (valid),
        .frame_err (frame_err)
`ifdef HC595_RX_DIGIT_CAP_EN
        ,
        .digits    (digits),
        .sel_err   (sel_err)
`endif
    );

    typedef struct {
        string       name;
        logic        en;
        int          nbits;
        logic [31:0] word;
        bit          coinc;
        bit          exp_v;
        bit          exp_f;
        logic [15:0] exp_data;
    } vec_t;

    vec_t tbl[7];

    int nvec  = 0;
    int nfail = 0;
    int v_cnt, f_cnt, both_cnt, lat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_50mhz);
        #1;
    endtask

    // Called just after st_clk is raised; watches a fixed window and drops both clocks
    task automatic monitor();
        v_cnt = 0; f_cnt = 0; both_cnt = 0; lat = -1;
`ifdef HC595_RX_DIGIT_CAP_EN
        se_cnt = 0; se_bad = 0;
`endif
        for (int k = 1; k <= 12; k++) begin
            step(1);
            if ((valid || frame_err) && lat < 0) lat = k;
            if (valid) v_cnt++;
            if (frame_err) f_cnt++;
            if (valid && frame_err) both_cnt++;
`ifdef HC595_RX_DIGIT_CAP_EN
            if (sel_err) se_cnt++;
            if (sel_err && !valid) se_bad++;
`endif
            if (k == 4) begin
                st_clk = 1'b0;
                sh_clk = 1'b0;
            end
        end
    endtask

    task automatic shift_bit(input logic b);
        ds = b; sh_clk = 1'b0;
        step(4);
        sh_clk = 1'b1;
        step(4);
    endtask

    task automatic send_frame(input int nbits, input logic [31:0] word, input bit coinc);
        for (int i = 0; i < nbits; i++) begin
            if (coinc && i == nbits - 1) begin
                ds = word[nbits-1-i]; sh_clk = 1'b0;
                step(4);
                sh_clk = 1'b1; st_clk = 1'b1;
                monitor();
            end else begin
                shift_bit(word[nbits-1-i]);
            end
        end
        if (!coinc) begin
            sh_clk = 1'b0;
            step(2);
            st_clk = 1'b1;
            monitor();
        end
        sh_clk = 1'b0;
        step(2);
    endtask

    task automatic check_result(input string name, input bit exp_v, input bit exp_f, input logic [15:0] exp_data);
        check({name, " valid_cycles"}, 64'(v_cnt), 64'(exp_v));
        check({name, " frame_err_cycles"}, 64'(f_cnt), 64'(exp_f));
        check({name, " valid_and_err"}, 64'(both_cnt), 64'd0);
        check({name, " data"}, 64'(data), 64'(exp_data));
        if (exp_v || exp_f) check({name, " latency"}, 64'(lat), 64'd3);
        if (exp_v) begin
            check({name, " seg"}, 64'(seg), 64'(exp_data[15:8]));
            check({name, " sel"}, 64'(sel), 64'(exp_data[7:0]));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ds = 1'b0; sh_clk = 1'b0; st_clk = 1'b0;
        step(3);
        check("reset data", 64'(data), 64'd0);
        check("reset valid", 64'(valid), 64'd0);
        check("reset frame_err", 64'(frame_err), 64'd0);
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        tbl[0] = '{"c0fe_full",      1'b1, 16, 32'h0000_C0FE, 1'b0, 1'b1, 1'b0, 16'hC0FE};
        tbl[1] = '{"short_15",       1'b1, 15, 32'h0000_7FFF, 1'b0, 1'b0, 1'b1, 16'hC0FE};
        tbl[2] = '{"long_17",        1'b1, 17, 32'h0001_2345, 1'b0, 1'b0, 1'b1, 16'hC0FE};
        tbl[3] = '{"coinc_1234",     1'b1, 16, 32'h0000_1234, 1'b1, 1'b0, 1'b1, 16'hC0FE};
        tbl[4] = '{"after_coinc_15", 1'b1, 15, 32'h0000_5678, 1'b0, 1'b1, 1'b0, 16'h5678};
        tbl[5] = '{"en_low_frame",   1'b0, 16, 32'h0000_BEEF, 1'b0, 1'b0, 1'b0, 16'h5678};
        tbl[6] = '{"en_back_0f0f",   1'b1, 16, 32'h0000_0F0F, 1'b0, 1'b1, 1'b0, 16'h0F0F};

        en = 1'b1;
        do_reset();

        for (int v = 0; v < 7; v++) begin
            en = tbl[v].en;
            send_frame(tbl[v].nbits, tbl[v].word, tbl[v].coinc);
            en = 1'b1;
            check_result(tbl[v].name, tbl[v].exp_v, tbl[v].exp_f, tbl[v].exp_data);
        end

        // Reset in the middle of a frame discards the partial bits
        for (int i = 0; i < 8; i++) shift_bit(1'b1);
        sh_clk = 1'b0;
        step(1);
        rst_n = 1'b0;
        #1;
        check("midreset data", 64'(data), 64'd0);
        step(2);
        check("midreset valid", 64'(valid), 64'd0);
        check("midreset frame_err", 64'(frame_err), 64'd0);
        rst_n = 1'b1;
        step(2);
        send_frame(16, 32'h0000_A55A, 1'b0);
        check_result("post_reset_a55a", 1'b1, 1'b0, 16'hA55A);
        send_frame(0, 32'h0, 1'b0);
        check_result("bare_latch", 1'b0, 1'b1, 16'hA55A);

`ifdef HC595_RX_DIGIT_CAP_EN
        do_reset();
        check("digits reset", digits, {8{8'hFF}});
        send_frame(16, 32'h0000_92FB, 1'b0);
        check_result("dig_92fb", 1'b1, 1'b0, 16'h92FB);
        check("dig_92fb sel_err", 64'(se_cnt), 64'd0);
        send_frame(16, 32'h0000_F9FE, 1'b0);
        check_result("dig_f9fe", 1'b1, 1'b0, 16'hF9FE);
        check("dig_f9fe sel_err", 64'(se_cnt), 64'd0);
        check("digits after two", digits, 64'hFFFF_FFFF_FF92_FFF9);
        send_frame(16, 32'h0000_00FC, 1'b0);
        check_result("dig_00fc", 1'b1, 1'b0, 16'h00FC);
        check("dig_00fc sel_err", 64'(se_cnt), 64'd1);
        check("dig_00fc sel_err_alone", 64'(se_bad), 64'd0);
        check("digits unchanged", digits, 64'hFFFF_FFFF_FF92_FFF9);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
